// File: rtl/ars_sha1_core_if.sv
// Host-side bus of the SHA-1 compression engine: block loading, start/chaining
// control and the digest/status outputs.
interface ars_sha1_core_if;
   logic         start;
   logic         load;
   logic [31:0]  din;
   logic [159:0] cv;
   logic         use_prev_cv;
   logic         busy;
   logic         ready;
   logic [159:0] cv_next;
   logic [31:0]  w;

   modport master (
      output start, load, din, cv, use_prev_cv,
      input  busy, ready, cv_next, w
   );

   modport slave (
      input  start, load, din, cv, use_prev_cv,
      output busy, ready, cv_next, w
   );
endinterface

// File: rtl/ars_sha1_core.sv
// SHA-1 compression engine, one round per clock, 81-cycle busy window per block.
// Optional macro ARS_SHA1_WTAP_EN exposes the per-round schedule word on w.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; load shifts words into the block buffer
// S_ROUND | rounds 0..79, one per clock, schedule expanded in the buffer
// S_FINAL | add working vars to latched chaining value, pulse ready
module ars_sha1_core (
   input  logic            clk,
   input  logic            reset,
   ars_sha1_core_if.slave  bus
);

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL} state_t;

   state_t       state;
   logic [31:0]  blk [16];
   logic [31:0]  a, b, c, d, e;
   logic [159:0] cv_lat;
   logic [6:0]   rnd;
   logic         busy_r;
   logic         ready_r;
   logic [159:0] cv_next_r;

   logic [31:0]  f;
   logic [31:0]  k;
   logic [31:0]  t_sum;
   logic [31:0]  w_mix;
   logic [31:0]  w_sched;
   logic [159:0] cv_sel;

   always_comb begin
      f = '0;
      k = '0;
      if (rnd < 7'd20) begin
         f = (b & c) | (~b & d);
         k = 32'h5A827999;
      end else if (rnd < 7'd40) begin
         f = b ^ c ^ d;
         k = 32'h6ED9EBA1;
      end else if (rnd < 7'd60) begin
         f = (b & c) | (b & d) | (c & d);
         k = 32'h8F1BBCDC;
      end else begin
         f = b ^ c ^ d;
         k = 32'hCA62C1D6;
      end
   end

   // blk[0] always holds W_t; the window slides one word per round so the
   // next-needed word W_{t+16} is appended at the tail.
   assign t_sum   = {a[26:0], a[31:27]} + f + e + k + blk[0];
   assign w_mix   = blk[13] ^ blk[8] ^ blk[2] ^ blk[0];
   assign w_sched = {w_mix[30:0], w_mix[31]};
   assign cv_sel  = bus.use_prev_cv ? cv_next_r : bus.cv;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= S_IDLE;
         a         <= '0;
         b         <= '0;
         c         <= '0;
         d         <= '0;
         e         <= '0;
         cv_lat    <= '0;
         rnd       <= '0;
         busy_r    <= 1'b0;
         ready_r   <= 1'b0;
         cv_next_r <= '0;
         for (int i = 0; i < 16; i++) blk[i] <= '0;
      end else begin
         ready_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.load) begin
                  for (int i = 0; i < 15; i++) blk[i] <= blk[i+1];
                  blk[15] <= bus.din;
               end
               if (bus.start) begin
                  cv_lat <= cv_sel;
                  a      <= cv_sel[159:128];
                  b      <= cv_sel[127:96];
                  c      <= cv_sel[95:64];
                  d      <= cv_sel[63:32];
                  e      <= cv_sel[31:0];
                  rnd    <= '0;
                  busy_r <= 1'b1;
                  state  <= S_ROUND;
               end
            end
            S_ROUND: begin
               a <= t_sum;
               b <= a;
               c <= {b[1:0], b[31:2]};
               d <= c;
               e <= d;
               for (int i = 0; i < 15; i++) blk[i] <= blk[i+1];
               blk[15] <= w_sched;
               if (rnd == 7'd79) begin
                  state <= S_FINAL;
               end else begin
                  rnd <= rnd + 7'd1;
               end
            end
            S_FINAL: begin
               cv_next_r <= {cv_lat[159:128] + a,
                             cv_lat[127:96]  + b,
                             cv_lat[95:64]   + c,
                             cv_lat[63:32]   + d,
                             cv_lat[31:0]    + e};
               busy_r  <= 1'b0;
               ready_r <= 1'b1;
               rnd     <= '0;
               state   <= S_IDLE;
            end
            default: begin
               busy_r <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

`ifdef ARS_SHA1_WTAP_EN
   logic [31:0] w_r;

   always_ff @(posedge clk) begin
      if (!reset) begin
         w_r <= '0;
      end else if (state == S_ROUND) begin
         w_r <= blk[0];
      end
   end

   assign bus.w = w_r;
`else
   assign bus.w = 32'h0;
`endif

   assign bus.busy    = busy_r;
   assign bus.ready   = ready_r;
   assign bus.cv_next = cv_next_r;

endmodule

// File: tb/tb_ars_sha1_core.sv
// Scoreboard bench for ars_sha1_core: expected digests queued at start,
// checked by a monitor on every ready pulse.
module tb_ars_sha1_core;

   typedef logic [31:0] blk_t [16];
   typedef struct packed {
      logic         chk;
      logic [159:0] val;
   } exp_t;

   localparam logic [159:0] IV    = 160'h67452301EFCDAB8998BADCFE10325476C3D2E1F0;
   localparam logic [159:0] D_ABC = 160'ha9993e364706816aba3e25717850c26c9cd0d89d;
   localparam logic [159:0] D_TWO = 160'h84983e441c3bd26ebaae4aa1f95129e5e54670f1;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ars_sha1_core_if bus();

   ars_sha1_core dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   exp_t sb[$];
   exp_t ent;
   int   checks     = 0;
   int   errors     = 0;
   int   ready_seen = 0;

   blk_t blk_abc;
   blk_t blk_m1;
   blk_t blk_m2;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (bus.ready === 1'b1) begin
         ready_seen++;
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready: got ready with cv_next %h, expected no ready", bus.cv_next);
         end else begin
            ent = sb.pop_front();
            if (ent.chk) chk("digest", bus.cv_next, ent.val);
         end
      end
   end

   task automatic load_block(input blk_t blk);
      for (int i = 0; i < 16; i++) begin
         bus.load = 1'b1;
         bus.din  = blk[i];
         @(negedge clk);
      end
      bus.load = 1'b0;
      bus.din  = '0;
   endtask

   // mode 0: plain run, 1: reset at round 40, 2: start/load garbage while busy
   task automatic run(input blk_t blk, input logic up, input logic [159:0] cvin,
                      input logic dochk, input logic [159:0] exp, input int mode,
                      input logic wchk);
      int n;
      int k;
      int rdy_before;
      load_block(blk);
      if (mode != 1) sb.push_back('{chk: dochk, val: exp});
      bus.start       = 1'b1;
      bus.use_prev_cv = up;
      bus.cv          = cvin;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      k = 0;
      rdy_before = ready_seen;
      while (bus.busy === 1'b1 && k < 200) begin
         n++;
         if (wchk) begin
`ifdef ARS_SHA1_WTAP_EN
            if (k == 1)  chk("w_round0",  160'(bus.w), 160'h61626380);
            if (k == 2)  chk("w_round1",  160'(bus.w), 160'h00000000);
            if (k == 16) chk("w_round15", 160'(bus.w), 160'h00000018);
`else
            if (k == 1 || k == 16) chk("w_tied_zero", 160'(bus.w), 160'h0);
`endif
         end
         if (mode == 2) begin
            bus.start = (k == 10);
            bus.load  = (k >= 20 && k < 36);
            bus.din   = $urandom;
         end
         if (mode == 1 && k == 40) reset = 1'b0;
         @(negedge clk);
         k++;
      end
      bus.start = 1'b0;
      bus.load  = 1'b0;
      bus.din   = '0;
      if (mode == 1) begin
         chk("abort_busy",    160'(bus.busy),  160'h0);
         chk("abort_cv_next", bus.cv_next,     160'h0);
         chk("abort_ready",   160'(bus.ready), 160'h0);
         reset = 1'b1;
         repeat (100) @(negedge clk);
         chk("abort_no_ready", 160'(ready_seen), 160'(rdy_before));
      end else begin
         chk("busy_cycles", 160'(n), 160'd81);
         repeat (3) @(negedge clk);
      end
   endtask

   initial begin
      blk_abc = '{default: 32'h0};
      blk_abc[0]  = 32'h61626380;
      blk_abc[15] = 32'h00000018;

      blk_m1 = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                 32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                 32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      blk_m2 = '{default: 32'h0};
      blk_m2[15] = 32'h000001c0;

      reset           = 1'b0;
      bus.start       = 1'b0;
      bus.load        = 1'b0;
      bus.din         = '0;
      bus.cv          = '0;
      bus.use_prev_cv = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_busy",    160'(bus.busy),  160'h0);
      chk("reset_ready",   160'(bus.ready), 160'h0);
      chk("reset_cv_next", bus.cv_next,     160'h0);
      chk("reset_w",       160'(bus.w),     160'h0);
      reset = 1'b1;
      @(negedge clk);

      run(blk_abc, 1'b0, IV, 1'b1, D_ABC, 0, 1'b1);

      run(blk_m1, 1'b0, IV, 1'b0, 160'h0, 0, 1'b0);
      run(blk_m2, 1'b1, IV, 1'b1, D_TWO, 0, 1'b0);

      run(blk_abc, 1'b0, IV, 1'b0, 160'h0, 1, 1'b0);
      run(blk_abc, 1'b0, IV, 1'b1, D_ABC, 0, 1'b1);

      run(blk_abc, 1'b0, IV, 1'b1, D_ABC, 2, 1'b0);

      run(blk_abc, 1'b0, IV, 1'b1, D_ABC, 0, 1'b0);
      repeat (20) @(negedge clk);
      chk("cv_next_hold", bus.cv_next, D_ABC);
      run(blk_abc, 1'b0, IV, 1'b1, D_ABC, 0, 1'b0);

      repeat (5) @(negedge clk);
      chk("scoreboard_empty", 160'(sb.size()), 160'h0);
      chk("ready_count",      160'(ready_seen), 160'd7);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ars_sha1_core.md
Name: ars_sha1_core

Overview:
Single-block SHA-1 compression engine (FIPS 180-4), one round per clock. A 512-bit message block is loaded as 16 big-endian 32-bit words. The block is compressed against a 160-bit chaining value taken either from the cv input or from the previous result. Multi-block hashing is done by chaining via use_prev_cv. Padding is done by the host.

Parameters:
none

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; begin compressing buffered block
din  in  32  message word; word 0 = bits [511:480] of block
load  in  1  write din into block buffer this cycle
cv  in  160  chaining value {H0,H1,H2,H3,H4}, H0 in [159:128]
use_prev_cv  in  1  sampled with start: 1 = chain from cv_next register, 0 = use cv
busy  out  1  high while compression in progress
ready  out  1  one-cycle pulse when cv_next updated
cv_next  out  160  result {H0'..H4'}, held until next completion or reset
w  out  32  schedule word W_t used in current round

Behaviour:
- Reset (reset=0 at rising edge): busy=0, ready=0, cv_next=0, w=0, round counter=0, block buffer cleared. Reset mid-compression aborts the operation; no ready pulse is produced.
- Block buffer: 16x32 shift register. Each edge with load=1 and busy=0 shifts din in at the tail. After 16 loads, the first word loaded is W0.
  - load is ignored while busy=1.
  - Fewer or more than 16 loads keeps the last 16 words written.
- Start: on an edge with start=1, busy=0 and reset=1:
  - Latch the chaining value: cv_next register if use_prev_cv=1, else cv.
  - Initialise a..e from the chaining value; round t=0; busy<=1.
  - start while busy=1 is ignored.
- Rounds: one per clock for t=0..79.
  - W_t = buffer word for t<16; for t>=16, W_t = ROTL1(W_{t-3}^W_{t-8}^W_{t-14}^W_{t-16}), computed in place in the 16-word circular buffer.
  - f/K: t 0-19 Ch, 5A827999; t 20-39 Parity, 6ED9EBA1; t 40-59 Maj, 8F1BBCDC; t 60-79 Parity, CA62C1D6.
  - Update: T = ROTL5(a)+f+e+K+W_t (mod 2^32); e<=d; d<=c; c<=ROTL30(b); b<=a; a<=T.
- Finalise (one extra cycle after round 79):
  - cv_next <= latched chaining value + {a,b,c,d,e}, each 32-bit word added mod 2^32.
  - busy<=0; ready<=1 for exactly one cycle.
- Latency: busy is high for exactly 81 clock cycles, starting from the edge that samples start. cv_next is valid when busy falls.
- The block buffer is consumed by compression. The host must reload all 16 words before the next start.
- w output is registered W_t of the current round; it holds its last value when idle.

Optional Feature:
ARS_SHA1_WTAP_EN
- Defined: w output drives W_t as described above.
- Undefined: w is tied to 32'h0 and its register and mux are removed. Digest behaviour and timing are unchanged.

Test Plan:
- Single block "abc": load padded block {"abc",80,0...,len=0x18} as 16 words; cv=67452301EFCDAB8998BADCFE10325476C3D2E1F0; pulse start → busy high 81 cycles, one ready pulse, cv_next = a9993e364706816aba3e25717850c26c9cd0d89d.
- Two-block chain, message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Block 1 = message + 80 + zeros, start with use_prev_cv=0.
  - Block 2 = 448 zero bits + length 0x1C0, start with use_prev_cv=1 (cv still IV, must be ignored).
  - Required: cv_next = 84983e441c3bd26ebaae4aa1f95129e5e54670f1.
- Reset mid-operation: assert reset=0 at round 40 of the "abc" run → busy=0, cv_next=0, no ready. Then rerun "abc" → correct digest.
- start and load while busy: pulse start and drive 16 load cycles of garbage during the "abc" run → no restart, digest still a9993e36...; buffer unchanged by those loads.
- Back-to-back "abc" runs with use_prev_cv=0 → identical digests; cv_next holds its value between runs until the next ready pulse.
- With ARS_SHA1_WTAP_EN, "abc": w = 61626380 in round 0, 00000000 in round 1, 00000018 in round 15. Without the macro, w stays 0.
